deserializer: RTL and testbench
===============================

// Module: deserializer
// PURPOSE
//   Receive-side counterpart of the serializer. Samples a 1-bit MSB-first stream
//   qualified by ser_data_val_i and rebuilds parallel words of up to DATA_W bits.
//   A burst of DATA_W bits, or a shorter burst closed by valid dropping, is
//   presented as a left-aligned word plus its bit count in serializer data_mod
//   encoding. Sits at the link input, feeding parallel consumers.
// PARAMETERS
//   DATA_W   16                Parallel word width, in bits.
//   MOD_W    $clog2(DATA_W)    Width of the bit-count output (4).
//   MIN_LEN  3                 Minimum burst length; shorter bursts are dropped.
// PORTS
//   clk_i             in   1       Clock. All logic on the rising edge.
//   srst_n_i          in   1       Synchronous reset, active-low.
//   ser_data_i        in   1       Serial data bit, MSB first.
//   ser_data_val_i    in   1       ser_data_i valid in this cycle.
//   deser_data_o      out  DATA_W  Word, left-aligned; unreceived LSBs are 0.
//   deser_data_mod_o  out  MOD_W   Bits received, mod DATA_W (0 means DATA_W).
//   deser_data_val_o  out  1       One-cycle pulse: deser_data_o/mod_o are valid.
//   drop_o            out  1       One-cycle pulse: a runt burst was discarded.
// BEHAVIOUR
//   Reset: when srst_n_i=0 at an edge, all outputs go to 0, cnt=0, shift reg=0,
//     FSM=IDLE. Any partial word is discarded with no pulse. Reset beats all else.
//   FSM IDLE: val=1 -> write bit at sreg[DATA_W-1], cnt=1, go to SHIFT.
//     val=0 -> stay in IDLE.
//   FSM SHIFT with val=1: write bit at sreg[DATA_W-1-cnt], cnt++.
//     - At bit number DATA_W: at the same edge, register deser_data_o=full word,
//       mod_o=0, val_o=1. Then cnt=0, sreg=0, go to IDLE.
//     - If val is still 1 in the next cycle, that bit starts a new word.
//   FSM SHIFT with val=0 (burst end):
//     - cnt>=MIN_LEN -> register data=sreg, mod_o=cnt, val_o=1.
//     - cnt<MIN_LEN  -> drop_o=1, data/mod unchanged.
//     - Both cases: cnt=0, sreg=0, go to IDLE.
//   Latency: output is visible in the cycle after the edge that sampled the last
//     bit (full word) or the edge that sampled val=0 (partial word).
//   deser_data_o and deser_data_mod_o hold their value between pulses.
//   val_o and drop_o are never high together, and each is high for 1 cycle only.
//   Framing contract: the transmitter inserts >=1 idle cycle between words
//     shorter than DATA_W. Full words may be back-to-back.
//   cnt is MOD_W+1 bits wide so it can reach DATA_W without wrapping.
//     ser_data_i is ignored when val=0.
// TESTING
//   1. 16 back-to-back bits of 0xA5C3, then idle -> one pulse, data=0xA5C3,
//      mod=0, 1 cycle after the 16th bit.
//   2. Two words 0x1234 and 0xFFFF with no gap (32 cycles of val=1) ->
//      two pulses 16 cycles apart, in order.
//   3. 5-bit burst 1,0,1,1,0 then val=0 -> data=0xB000, mod=5,
//      pulse 1 cycle after val falls.
//   4. 2-bit burst then val=0 -> drop_o pulse, no val_o, data/mod keep the
//      previous word.
//   5. srst_n_i=0 after 9 bits -> outputs 0, no pulse. A following 16-bit word
//      0x0F0F is received intact.
//   6. Random: 1000 words, random data and mod (per serializer rules), random
//      gaps -> scoreboard compares data/mod against the sent queue; runts
//      match drop_o.

Source files
------------

// File: rtl/deserializer_if.sv
// Serial-in / parallel-out link bundle for the deserializer.
// The transmitter drives the serial side; the deserializer drives the parallel side.
interface deserializer_if #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
);
    logic              ser_data_i;
    logic              ser_data_val_i;
    logic [DATA_W-1:0] deser_data_o;
    logic [MOD_W-1:0]  deser_data_mod_o;
    logic              deser_data_val_o;
    logic              drop_o;

    modport master (
        output ser_data_i,
        output ser_data_val_i,
        input  deser_data_o,
        input  deser_data_mod_o,
        input  deser_data_val_o,
        input  drop_o
    );

    modport slave (
        input  ser_data_i,
        input  ser_data_val_i,
        output deser_data_o,
        output deser_data_mod_o,
        output deser_data_val_o,
        output drop_o
    );
endinterface

// File: rtl/deserializer.sv
// Rebuilds left-aligned parallel words from an MSB-first serial burst; a burst
// ends at DATA_W bits or when valid drops, and runts below MIN_LEN are dropped.
module deserializer #(
    parameter int DATA_W  = 16,
    parameter int MOD_W   = $clog2(DATA_W),
    parameter int MIN_LEN = 3
) (
    input  logic          clk_i,
    input  logic          srst_n_i,
    deserializer_if.slave bus
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [MOD_W:0] LAST_CNT = (MOD_W+1)'(DATA_W - 1);
    localparam logic [MOD_W:0] MIN_CNT  = (MOD_W+1)'(MIN_LEN);
    localparam logic [MOD_W:0] ONE_CNT  = (MOD_W+1)'(1);

    state_t            r_state;
    logic [MOD_W:0]    r_cnt;
    logic [DATA_W-1:0] r_sreg;
    logic [DATA_W-1:0] r_data;
    logic [MOD_W-1:0]  r_mod;
    logic              r_val;
    logic              r_drop;

    logic [MOD_W-1:0]  w_pos;
    logic [DATA_W-1:0] w_sreg_ins;

    // r_cnt is 0 in IDLE, so the first bit lands at the MSB as well.
    assign w_pos = MOD_W'(DATA_W - 1) - r_cnt[MOD_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ins
            assign w_sreg_ins[gi] = (w_pos == MOD_W'(gi)) ? bus.ser_data_i : r_sreg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_data  <= '0;
            r_mod   <= '0;
            r_val   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_val  <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ser_data_val_i) begin
                        r_sreg  <= w_sreg_ins;
                        r_cnt   <= ONE_CNT;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.ser_data_val_i) begin
                        if (r_cnt == LAST_CNT) begin
                            r_data  <= w_sreg_ins;
                            r_mod   <= '0;
                            r_val   <= 1'b1;
                            r_cnt   <= '0;
                            r_sreg  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_sreg <= w_sreg_ins;
                            r_cnt  <= r_cnt + ONE_CNT;
                        end
                    end else begin
                        // Burst closed early: publish or discard, then rearm.
                        if (r_cnt >= MIN_CNT) begin
                            r_data <= r_sreg;
                            r_mod  <= r_cnt[MOD_W-1:0];
                            r_val  <= 1'b1;
                        end else begin
                            r_drop <= 1'b1;
                        end
                        r_cnt   <= '0;
                        r_sreg  <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.deser_data_o     = r_data;
    assign bus.deser_data_mod_o = r_mod;
    assign bus.deser_data_val_o = r_val;
    assign bus.drop_o           = r_drop;
endmodule

// File: tb/tb_deserializer.sv
// Randomised and directed bench for the deserializer, checked every cycle
// against a burst-level model keyed by the clock edge that closes each burst.
module tb_deserializer;
    localparam int DATA_W  = 16;
    localparam int MOD_W   = 4;
    localparam int MIN_LEN = 3;

    logic clk;
    logic srst_n;
    int   edge_cnt;
    int   tests;
    int   fails;

    deserializer_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

    deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W), .MIN_LEN(MIN_LEN)) dut (
        .clk_i    (clk),
        .srst_n_i (srst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Expectations indexed by the edge number whose result they describe.
    int          exp_kind [int];   // 1 = word pulse, 2 = drop pulse
    logic [15:0] exp_data [int];
    logic [3:0]  exp_mod  [int];
    bit          rst_at   [int];
    int          exp_val_count;
    int          exp_drop_count;
    int          val_edges [$];
    int          drop_edges [$];
    logic [15:0] held_data;
    logic [3:0]  held_mod;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endfunction

    // Per-cycle comparison of {val, drop, mod, data} against the model.
    logic        e_val;
    logic        e_drop;
    logic [15:0] e_data;
    logic [3:0]  e_mod;
    int          n;
    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            n      = edge_cnt;
            e_val  = 1'b0;
            e_drop = 1'b0;
            if (rst_at.exists(n)) begin
                held_data = '0;
                held_mod  = '0;
            end else if (exp_kind.exists(n)) begin
                if (exp_kind[n] == 1) begin
                    e_val     = 1'b1;
                    held_data = exp_data[n];
                    held_mod  = exp_mod[n];
                end else begin
                    e_drop = 1'b1;
                end
            end
            e_data = held_data;
            e_mod  = held_mod;
            check("cycle", 64'({bus.deser_data_val_o, bus.drop_o, bus.deser_data_mod_o, bus.deser_data_o}),
                  64'({e_val, e_drop, e_mod, e_data}));
            if (bus.deser_data_val_o === 1'b1) val_edges.push_back(n);
            if (bus.drop_o === 1'b1) drop_edges.push_back(n);
        end
    end

    task automatic drive(input bit v, input bit d, input bit rn, output int e);
        bus.ser_data_i     = d;
        bus.ser_data_val_i = v;
        srst_n             = rn;
        e = edge_cnt + 1;
        if (!rn) rst_at[e] = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic add_exp(input int e, input int kind, input logic [15:0] d, input logic [3:0] m);
        exp_kind[e] = kind;
        exp_data[e] = d;
        exp_mod[e]  = m;
        if (kind == 1) exp_val_count++;
        else exp_drop_count++;
    endtask

    // Sends the top len bits of data MSB first, then gap idle cycles.
    task automatic send_word(input logic [15:0] data, input int len, input int gap);
        int          e;
        int          g;
        logic [15:0] mask;
        logic [15:0] word;
        word = data;
        for (int i = 0; i < len; i++) begin
            drive(1'b1, word[15-i], 1'b1, e);
            if (len == 16 && i == 15) add_exp(e, 1, word, 4'd0);
        end
        g = gap;
        if (len < 16 && g < 1) g = 1;
        for (int k = 0; k < g; k++) begin
            drive(1'b0, 1'($urandom), 1'b1, e);
            if (k == 0 && len < 16) begin
                mask = 16'hFFFF;
                mask = ~(mask >> len);
                if (len >= MIN_LEN) add_exp(e, 1, word & mask, 4'(len));
                else add_exp(e, 2, 16'h0, 4'h0);
            end
        end
    endtask

    initial begin
        int          e;
        int          len;
        int          gap;
        logic [15:0] d;

        tests = 0;
        fails = 0;
        exp_val_count  = 0;
        exp_drop_count = 0;
        held_data = '0;
        held_mod  = '0;
        bus.ser_data_i     = 1'b0;
        bus.ser_data_val_i = 1'b0;
        srst_n             = 1'b0;

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, e);
        check("reset_out", 64'({bus.deser_data_val_o, bus.drop_o, bus.deser_data_mod_o, bus.deser_data_o}), 64'h0);
        drive(1'b0, 1'b0, 1'b1, e);

        send_word(16'hA5C3, 16, 3);
        check("t1_data", 64'({bus.deser_data_mod_o, bus.deser_data_o}), 64'h0_A5C3);
        check("t1_pulses", 64'(val_edges.size()), 64'd1);

        send_word(16'h1234, 16, 0);
        send_word(16'hFFFF, 16, 3);
        check("t2_data", 64'(bus.deser_data_o), 64'hFFFF);
        check("t2_pulses", 64'(val_edges.size()), 64'd3);
        if (val_edges.size() == 3)
            check("t2_spacing", 64'(val_edges[2] - val_edges[1]), 64'd16);

        send_word(16'hB000, 5, 3);
        check("t3_data", 64'({bus.deser_data_mod_o, bus.deser_data_o}), 64'h5_B000);

        send_word(16'hC000, 2, 3);
        check("t4_hold", 64'({bus.deser_data_mod_o, bus.deser_data_o}), 64'h5_B000);
        check("t4_drops", 64'(drop_edges.size()), 64'd1);
        check("t4_pulses", 64'(val_edges.size()), 64'd4);

        d = 16'h6D5A;
        for (int i = 0; i < 9; i++) drive(1'b1, d[15-i], 1'b1, e);
        drive(1'b0, 1'b0, 1'b0, e);
        check("t5_reset", 64'({bus.deser_data_val_o, bus.drop_o, bus.deser_data_mod_o, bus.deser_data_o}), 64'h0);
        send_word(16'h0F0F, 16, 3);
        check("t5_data", 64'({bus.deser_data_mod_o, bus.deser_data_o}), 64'h0_0F0F);
        check("t5_pulses", 64'(val_edges.size()), 64'd5);

        for (int w = 0; w < 1000; w++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) len = 16;
            else len = $urandom_range(1, 16);
            gap = $urandom_range(0, 3);
            send_word(d, len, gap);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, e);

        check("total_pulses", 64'(val_edges.size()), 64'(exp_val_count));
        check("total_drops", 64'(drop_edges.size()), 64'(exp_drop_count));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
